// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes,
// datapath select values and the packed control word.
package mips_pkg;

  typedef logic [3:0] statetype_t;

  localparam statetype_t FETCH   = 4'd0;
  localparam statetype_t DECODE  = 4'd1;
  localparam statetype_t MEMADR  = 4'd2;
  localparam statetype_t MEMRD   = 4'd3;
  localparam statetype_t MEMWB   = 4'd4;
  localparam statetype_t MEMWR   = 4'd5;
  localparam statetype_t RTYPEEX = 4'd6;
  localparam statetype_t RTYPEWB = 4'd7;
  localparam statetype_t BEQEX   = 4'd8;
  localparam statetype_t ADDIEX  = 4'd9;
  localparam statetype_t ADDIWB  = 4'd10;
  localparam statetype_t JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // aludec imports these same constants, so keep them in sync with it
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps the controller state to the datapath control word.
// mem_ready only gates the FETCH strobes so a stalled fetch writes nothing.
module mc_outdec
  import mips_pkg::*;
(
  input  statetype_t state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// reset gating of all write strobes. Output decode lives in mc_outdec.
module mc_controller_fsm
  import mips_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  statetype_t state;
  statetype_t state_next;
  ctrl_t      ctrl;
  logic       mem_ok;

  assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      // Anything other than sw is treated as a load here
      MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = mem_ok ? MEMWB : MEMRD;
      MEMWB:   state_next = FETCH;
      MEMWR:   state_next = mem_ok ? FETCH : MEMWR;
      RTYPEEX: state_next = RTYPEWB;
      RTYPEWB: state_next = FETCH;
      BEQEX:   state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JEX:     state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ok),
    .ctrl      (ctrl)
  );

  // Strobes are forced low during reset so an abandoned instruction never writes
  assign pcen       = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
  assign irwrite    = ~reset & ctrl.irwrite;
  assign memwrite   = ~reset & ctrl.memwrite;
  assign regwrite   = ~reset & ctrl.regwrite;
  assign illegal_op = ~reset & (state == DECODE) & ~is_legal_op(op);

  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign state_o  = state;

endmodule

// File: tb/tb_mc_controller_fsm.sv
// Scoreboard bench for mc_controller_fsm: directed per-cycle vectors push the
// hand-computed expected control word; a negedge monitor pops and compares.
module tb_mc_controller_fsm;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state_o;
  logic       illegal_op;

  typedef struct {
    string       name;
    logic [19:0] word;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [5:0] OP_BAD = 6'b111111;

  always #5 clk = ~clk;

  mc_controller_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .state_o    (state_o),
    .illegal_op (illegal_op)
  );

  // strobes = {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca}
  function automatic logic [19:0] w(input logic [3:0] st, input logic [7:0] strobes,
                                    input logic [1:0] srcb, input logic [1:0] psrc,
                                    input logic [2:0] aop, input logic ill);
    return {st, strobes, srcb, psrc, aop, ill};
  endfunction

  task automatic applyStimulus(input string name, input logic rst, input logic [5:0] opc,
                               input logic z, input logic mr, input logic [19:0] exp_word);
    exp_t item;
    @(posedge clk);
    #1;
    reset     = rst;
    op        = opc;
    zero      = z;
    mem_ready = mr;
    item.name = name;
    item.word = exp_word;
    sb.push_back(item);
  endtask

  task automatic checkOutput(input exp_t item);
    logic [19:0] got;
    got = {state_o, pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
           alusrcb, pcsrc, aluop, illegal_op};
    tests_run++;
    if (got !== item.word) begin
      tests_failed++;
      $display("[TB] FAIL %s: got state=%0d strb=%b srcb=%b pcsrc=%b aluop=%b ill=%b, expected state=%0d strb=%b srcb=%b pcsrc=%b aluop=%b ill=%b",
               item.name, got[19:16], got[15:8], got[7:6], got[5:4], got[3:1], got[0],
               item.word[19:16], item.word[15:8], item.word[7:6], item.word[5:4],
               item.word[3:1], item.word[0]);
    end
  endtask

  initial begin
    exp_t item;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        checkOutput(item);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; op = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;

    applyStimulus("reset1",      1, OP_LW,  0, 1, w(FETCH,   8'b00000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("reset2",      1, OP_LW,  0, 1, w(FETCH,   8'b00000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("lw_fetch",    0, OP_LW,  0, 1, w(FETCH,   8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("lw_decode",   0, OP_LW,  0, 1, w(DECODE,  8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("lw_memadr",   0, OP_LW,  0, 1, w(MEMADR,  8'b00000001, 2'b10, 2'b00, 3'b000, 0));
    applyStimulus("lw_memrd",    0, OP_BAD, 0, 1, w(MEMRD,   8'b00001000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("lw_memwb",    0, OP_BAD, 0, 1, w(MEMWB,   8'b00010100, 2'b00, 2'b00, 3'b000, 0));

    applyStimulus("sw_fetch",    0, OP_SW,  0, 1, w(FETCH,   8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("sw_decode",   0, OP_SW,  0, 1, w(DECODE,  8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("sw_memadr",   0, OP_SW,  0, 1, w(MEMADR,  8'b00000001, 2'b10, 2'b00, 3'b000, 0));
    applyStimulus("sw_wait1",    0, OP_SW,  0, 0, w(MEMWR,   8'b00101000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("sw_wait2",    0, OP_SW,  0, 0, w(MEMWR,   8'b00101000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("sw_wait3",    0, OP_SW,  0, 0, w(MEMWR,   8'b00101000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("sw_done",     0, OP_SW,  0, 1, w(MEMWR,   8'b00101000, 2'b00, 2'b00, 3'b000, 0));

    applyStimulus("r_fetch",     0, OP_RTYPE, 0, 1, w(FETCH,   8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("r_decode",    0, OP_RTYPE, 0, 1, w(DECODE,  8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("r_ex",        0, OP_RTYPE, 0, 1, w(RTYPEEX, 8'b00000001, 2'b00, 2'b00, 3'b010, 0));
    applyStimulus("r_wb",        0, OP_RTYPE, 0, 1, w(RTYPEWB, 8'b00010010, 2'b00, 2'b00, 3'b000, 0));

    applyStimulus("beq1_fetch",  0, OP_BEQ, 0, 1, w(FETCH,   8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("beq1_decode", 0, OP_BEQ, 0, 1, w(DECODE,  8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("beq_taken",   0, OP_BEQ, 1, 1, w(BEQEX,   8'b10000001, 2'b00, 2'b01, 3'b001, 0));
    applyStimulus("beq0_fetch",  0, OP_BEQ, 0, 1, w(FETCH,   8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("beq0_decode", 0, OP_BEQ, 0, 1, w(DECODE,  8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("beq_nottkn",  0, OP_BEQ, 0, 1, w(BEQEX,   8'b00000001, 2'b00, 2'b01, 3'b001, 0));

    applyStimulus("addi_fetch",  0, OP_ADDI, 0, 1, w(FETCH,  8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("addi_decode", 0, OP_ADDI, 0, 1, w(DECODE, 8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("addi_ex",     0, OP_ADDI, 0, 1, w(ADDIEX, 8'b00000001, 2'b10, 2'b00, 3'b000, 0));
    applyStimulus("addi_wb",     0, OP_ADDI, 0, 1, w(ADDIWB, 8'b00010000, 2'b00, 2'b00, 3'b000, 0));

    applyStimulus("j_fetch",     0, OP_J, 0, 1, w(FETCH,  8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("j_decode",    0, OP_J, 0, 1, w(DECODE, 8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("j_ex",        0, OP_J, 0, 1, w(JEX,    8'b10000000, 2'b00, 2'b10, 3'b000, 0));

    applyStimulus("bad_fetch",   0, OP_BAD, 0, 1, w(FETCH,  8'b11000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("bad_decode",  0, OP_BAD, 0, 1, w(DECODE, 8'b00000000, 2'b11, 2'b00, 3'b000, 1));
    applyStimulus("fetch_stall1",0, OP_SW,  0, 0, w(FETCH,  8'b00000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("fetch_stall2",0, OP_SW,  0, 0, w(FETCH,  8'b00000000, 2'b01, 2'b00, 3'b000, 0));
    applyStimulus("fetch_go",    0, OP_SW,  0, 1, w(FETCH,  8'b11000000, 2'b01, 2'b00, 3'b000, 0));

    applyStimulus("rst_decode",  0, OP_SW,  0, 1, w(DECODE, 8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("rst_memadr",  0, OP_SW,  0, 1, w(MEMADR, 8'b00000001, 2'b10, 2'b00, 3'b000, 0));
    applyStimulus("rst_in_memwr",1, OP_SW,  0, 0, w(MEMWR,  8'b00001000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("rst_fetch",   0, OP_LW,  0, 1, w(FETCH,  8'b11000000, 2'b01, 2'b00, 3'b000, 0));

    applyStimulus("lwst_decode", 0, OP_LW,  0, 1, w(DECODE, 8'b00000000, 2'b11, 2'b00, 3'b000, 0));
    applyStimulus("lwst_memadr", 0, OP_LW,  0, 1, w(MEMADR, 8'b00000001, 2'b10, 2'b00, 3'b000, 0));
    applyStimulus("lwst_wait",   0, OP_SW,  0, 0, w(MEMRD,  8'b00001000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("lwst_rd",     0, OP_SW,  0, 1, w(MEMRD,  8'b00001000, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("lwst_wb",     0, OP_SW,  0, 1, w(MEMWB,  8'b00010100, 2'b00, 2'b00, 3'b000, 0));
    applyStimulus("lwst_fetch",  0, OP_SW,  0, 1, w(FETCH,  8'b11000000, 2'b01, 2'b00, 3'b000, 0));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
